video_reset_seq: RTL and testbench



---
 rtl/video_reset_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/video_reset_seq.sv | 87 ++++++++
 tb/tb_video_reset_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_reset_pkg.sv
// Shared state encoding and default timing for the video clock-tree reset sequencer.
package video_reset_pkg;

  localparam logic [1:0] ST_RESET     = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 250000;
  localparam int unsigned DEF_STABLE_CYCLES       = 1024;

  // Largest of three timing parameters, used to size the shared counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_reset_seq.sv
// Video PLL reset/lock sequencer: pulses PLL reset, waits for stable lock,
// then releases the video-domain reset; re-arms on lock loss or timeout.
module video_reset_seq
  import video_reset_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count,
  output logic [1:0] state
);

  localparam int unsigned CW =
    $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;

  logic          lock_s;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          pulse_done;
  logic          lock_timeout;
  logic          stable_done;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign pulse_done   = (cnt == CW'(RST_PULSE_CYCLES - 32'd1));
  assign lock_timeout = (cnt == CW'(LOCK_TIMEOUT_CYCLES - 32'd1));
  assign stable_done  = (cnt == CW'(STABLE_CYCLES - 32'd1));

  // Next-state logic; a lock change always wins over a counter expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:     if (pulse_done) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)            state_nxt = ST_STABLE;
        else if (lock_timeout) state_nxt = ST_RESET;
      end
      ST_STABLE: begin
        if (!lock_s)          state_nxt = ST_WAIT_LOCK;
        else if (stable_done) state_nxt = ST_RUN;
      end
      ST_RUN:       if (!lock_s) state_nxt = ST_WAIT_LOCK;
      default:      state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nxt;
  end

  // Shared counter restarts on every state change; outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      pll_rst       <= 1'b1;
      video_rst_n   <= 1'b0;
      ready         <= 1'b0;
      relock_count  <= 8'd0;
      timeout_count <= 8'd0;
    end else begin
      if (state_nxt != state || state == ST_RUN) cnt <= '0;
      else                                       cnt <= cnt + CW'(1);
      pll_rst     <= (state_nxt == ST_RESET);
      video_rst_n <= (state_nxt == ST_RUN);
      ready       <= (state_nxt == ST_RUN);
      if (state == ST_WAIT_LOCK && !lock_s && lock_timeout && timeout_count != 8'hFF)
        timeout_count <= timeout_count + 8'd1;
      if (state == ST_RUN && !lock_s && relock_count != 8'hFF)
        relock_count <= relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_reset_seq.sv
// Directed bench for video_reset_seq with short timing parameters.
module tb_video_reset_seq;

  localparam int unsigned RP = 4;
  localparam int unsigned LT = 100;
  localparam int unsigned SC = 8;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       video_rst_n;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;
  logic [1:0] state;

  int errors;
  int checks;

  video_reset_seq #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .STABLE_CYCLES       (SC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .video_rst_n   (video_rst_n),
    .ready         (ready),
    .relock_count  (relock_count),
    .timeout_count (timeout_count),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step(3);
    checks++;
    if ({pll_rst, video_rst_n, ready, state} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b vrst_n=%b rdy=%b st=%0d want 1 0 0 0",
               pll_rst, video_rst_n, ready, state);
    end
    checks++;
    if (relock_count !== 8'd0 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: got relock=%0d timeout=%0d want 0 0",
               relock_count, timeout_count);
    end
  endtask

  task automatic test_clean_start;
    rst_n = 1'b1;
    step(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL clean_pulse_high: pll_rst=%b after edge 3, want 1", pll_rst);
    end
    step(1);
    checks++;
    if (pll_rst !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL clean_pulse_end: pll_rst=%b st=%0d after edge 4, want 0 1", pll_rst, state);
    end
    step(16);
    pll_locked = 1'b1;
    step(2);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL clean_sync_delay: st=%0d after 2 edges, want 1", state);
    end
    step(1);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL clean_stable: st=%0d after 3 edges, want 2", state);
    end
    step(7);
    checks++;
    if (video_rst_n !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_early_release: vrst_n=%b rdy=%b after 10 edges, want 0 0",
               video_rst_n, ready);
    end
    step(1);
    checks++;
    if ({video_rst_n, ready, state} !== {1'b1, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL clean_run: vrst_n=%b rdy=%b st=%0d after 11 edges, want 1 1 3",
               video_rst_n, ready, state);
    end
    checks++;
    if (relock_count !== 8'd0 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL clean_counts: relock=%0d timeout=%0d want 0 0", relock_count, timeout_count);
    end
  endtask

  task automatic test_no_lock;
    int highs, rises, vrel;
    logic prev, at103, at104, at108;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    step(2);
    rst_n = 1'b1;
    highs = 0; rises = 0; vrel = 0;
    prev = 1'b1;
    at103 = 1'bx; at104 = 1'bx; at108 = 1'bx;
    for (int e = 1; e <= 400; e++) begin
      step(1);
      if (pll_rst === 1'b1) highs++;
      if (pll_rst === 1'b1 && prev === 1'b0) rises++;
      if (video_rst_n !== 1'b0) vrel++;
      if (e == 103) at103 = pll_rst;
      if (e == 104) at104 = pll_rst;
      if (e == 108) at108 = pll_rst;
      prev = pll_rst;
    end
    checks++;
    if (highs != 15 || rises != 3) begin
      errors++;
      $display("FAIL nolock_pulses: high samples=%0d pulses=%0d want 15 3", highs, rises);
    end
    checks++;
    if ({at103, at104, at108} !== 3'b010) begin
      errors++;
      $display("FAIL nolock_period: pll_rst at edges 103/104/108 = %b%b%b want 010",
               at103, at104, at108);
    end
    checks++;
    if (timeout_count !== 8'd3) begin
      errors++;
      $display("FAIL nolock_timeouts: timeout_count=%0d want 3", timeout_count);
    end
    checks++;
    if (vrel != 0) begin
      errors++;
      $display("FAIL nolock_video: video_rst_n high on %0d edges, want 0", vrel);
    end
  endtask

  task automatic test_unstable_lock;
    pll_locked = 1'b1;
    step(3);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL unstable_first_stable: st=%0d want 2", state);
    end
    step(2);
    pll_locked = 1'b0;
    step(2);
    pll_locked = 1'b1;
    step(10);
    checks++;
    if (state !== 2'd2 || video_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL unstable_not_yet: st=%0d vrst_n=%b 10 edges after re-rise, want 2 0",
               state, video_rst_n);
    end
    step(1);
    checks++;
    if (state !== 2'd3 || video_rst_n !== 1'b1 || relock_count !== 8'd0) begin
      errors++;
      $display("FAIL unstable_run: st=%0d vrst_n=%b relock=%0d want 3 1 0",
               state, video_rst_n, relock_count);
    end
  endtask

  task automatic test_lock_loss;
    int pulses;
    pll_locked = 1'b0;
    step(2);
    checks++;
    if (video_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: vrst_n=%b after 2 edges, want 1", video_rst_n);
    end
    step(1);
    checks++;
    if (video_rst_n !== 1'b0 || ready !== 1'b0 || state !== 2'd1 || relock_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_drop: vrst_n=%b rdy=%b st=%0d relock=%0d want 0 0 1 1",
               video_rst_n, ready, state, relock_count);
    end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (pll_rst !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL loss_no_pll_rst: pll_rst high on %0d edges, want 0", pulses);
    end
    pll_locked = 1'b1;
    step(11);
    checks++;
    if (state !== 2'd3 || video_rst_n !== 1'b1 || relock_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_rerun: st=%0d vrst_n=%b relock=%0d want 3 1 1",
               state, video_rst_n, relock_count);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(11);
      if (i == 252) begin
        checks++;
        if (relock_count !== 8'd254) begin
          errors++;
          $display("FAIL sat_pre: relock=%0d want 254", relock_count);
        end
      end
    end
    checks++;
    if (relock_count !== 8'd255 || state !== 2'd3) begin
      errors++;
      $display("FAIL sat_final: relock=%0d st=%0d want 255 3", relock_count, state);
    end
    checks++;
    if (timeout_count !== 8'd3) begin
      errors++;
      $display("FAIL sat_timeouts: timeout_count=%0d want 3", timeout_count);
    end
  endtask

  task automatic test_reset_mid_stable;
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(3);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL midreset_setup: st=%0d want 2", state);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, video_rst_n, ready, state} !== {1'b1, 1'b0, 1'b0, 2'd0} ||
        relock_count !== 8'd0 || timeout_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_async: rst=%b vrst_n=%b rdy=%b st=%0d relock=%0d tmo=%0d want 1 0 0 0 0 0",
               pll_rst, video_rst_n, ready, state, relock_count, timeout_count);
    end
    step(1);
    rst_n = 1'b1;
    step(4 + 11);
    checks++;
    if (video_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rerun: vrst_n=%b want 1", video_rst_n);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (pll_rst !== 1'b1 || video_rst_n !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_run_async: rst=%b vrst_n=%b rdy=%b want 1 0 0",
               pll_rst, video_rst_n, ready);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    test_reset;
    test_clean_start;
    test_no_lock;
    test_unstable_lock;
    test_lock_loss;
    test_saturation;
    test_reset_mid_stable;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
